// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and defaults for the framebuffer write scheduler
//
// Purpose: framebuffer geometry defaults, coordinate/colour types and the
// scheduler state encoding used by fb_write_scheduler.
package fb_pkg;

  localparam int FB_W_DEF = 640;
  localparam int FB_H_DEF = 480;

  typedef logic [10:0] coord_t;
  typedef logic [7:0]  color_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sched_state_t;

endpackage

// File: rtl/fb_write_scheduler_rr_arbiter.sv
// rtl/fb_write_scheduler_rr_arbiter.sv - combinational round-robin grant selection
//
// Purpose: picks the first requesting client at or after ptr (wrapping).
// Ports:
//   req       in   N   request vector
//   ptr       in   IW  search start index (held by the parent)
//   grant     out  N   one-hot grant, all zero when nothing requests
//   grant_idx out  IW  index of the granted client (0 when nothing requests)
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic w_found;
  int   w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found          = 1'b1;
        grant[w_idx]     = 1'b1;
        grant_idx        = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - shares the framebuffer write port between clients and a clear engine
//
// Purpose: round-robin arbitration of NREQ pixel clients onto one registered
// framebuffer write port, with a full-screen clear sweep that pre-empts clients.
// Ports:
//   CLOCK_50, reset_n                 clock, async active-low reset
//   req_valid/req_x/req_y/req_color   client pixel requests (valid/ready)
//   req_ready                         combinational accept per client
//   clear_start/clear_color           start a fill sweep with a colour
//   clear_busy/clear_done             sweep in progress / one-cycle completion pulse
//   fb_x/fb_y/fb_color/fb_write       registered framebuffer write port
//   drop_cnt                          saturating count of off-screen pixels discarded
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF,
  parameter int NREQ = 2
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0][10:0]  req_x,
  input  logic [NREQ-1:0][10:0]  req_y,
  input  logic [NREQ-1:0][7:0]   req_color,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   clear_start,
  input  logic [7:0]             clear_color,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic [10:0]            fb_x,
  output logic [10:0]            fb_y,
  output logic [7:0]             fb_color,
  output logic                   fb_write,
  output logic [15:0]            drop_cnt
);

  localparam int     PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam coord_t X_LIM  = coord_t'(FB_W);
  localparam coord_t Y_LIM  = coord_t'(FB_H);
  localparam coord_t X_LAST = coord_t'(FB_W - 1);
  localparam coord_t Y_LAST = coord_t'(FB_H - 1);

  sched_state_t r_state;
  logic [PW-1:0] r_ptr;
  coord_t        r_cx;
  coord_t        r_cy;
  color_t        r_clr_color;
  coord_t        r_fb_x;
  coord_t        r_fb_y;
  color_t        r_fb_color;
  logic          r_fb_write;
  logic          r_clear_done;
  logic [15:0]   r_drop_cnt;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_grant_idx;
  logic            w_xfer;
  logic            w_in_bounds;

  rr_arbiter #(
    .N  (NREQ),
    .IW (PW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // A clear request in IDLE takes the port this cycle, so no client is accepted.
  assign req_ready   = (r_state == IDLE && !clear_start) ? w_grant : '0;
  assign w_xfer      = |(req_valid & req_ready);
  assign w_in_bounds = (req_x[w_grant_idx] < X_LIM) && (req_y[w_grant_idx] < Y_LIM);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_clr_color  <= '0;
      r_fb_x       <= '0;
      r_fb_y       <= '0;
      r_fb_color   <= '0;
      r_fb_write   <= 1'b0;
      r_clear_done <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      // Write strobe and done are pulses; they only stay high while re-asserted.
      r_fb_write   <= 1'b0;
      r_clear_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear_start) begin
            r_state     <= CLEAR;
            r_clr_color <= clear_color;
            r_cx        <= '0;
            r_cy        <= '0;
          end else if (w_xfer) begin
            r_ptr <= (w_grant_idx == PW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
            if (w_in_bounds) begin
              r_fb_write <= 1'b1;
              r_fb_x     <= req_x[w_grant_idx];
              r_fb_y     <= req_y[w_grant_idx];
              r_fb_color <= req_color[w_grant_idx];
            end else if (r_drop_cnt != 16'hFFFF) begin
              r_drop_cnt <= r_drop_cnt + 16'd1;
            end
          end
        end
        CLEAR: begin
          r_fb_write <= 1'b1;
          r_fb_x     <= r_cx;
          r_fb_y     <= r_cy;
          r_fb_color <= r_clr_color;
          if (r_cx == X_LAST) begin
            r_cx <= '0;
            // Leaving on the last pixel lets done/busy line up with that pixel's write.
            if (r_cy == Y_LAST) begin
              r_state      <= IDLE;
              r_clear_done <= 1'b1;
            end else begin
              r_cy <= r_cy + 1'b1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign clear_busy = (r_state == CLEAR);
  assign clear_done = r_clear_done;
  assign fb_x       = r_fb_x;
  assign fb_y       = r_fb_y;
  assign fb_color   = r_fb_color;
  assign fb_write   = r_fb_write;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Shares the VGA framebuffer's single pixel-write port (`x`, `y`, `VGA_Cin`, `pixel_write`) between NREQ drawing clients and a built-in full-screen clear engine.
- Clients use a valid/ready handshake, arbitrated round-robin; an active clear has absolute priority.
- Off-screen writes are accepted and discarded, and counted.
- The block sits between the drawing logic and the framebuffer write port, in the CLOCK_50 domain.

## Interface
Parameters:
- `FB_W`, 640, framebuffer width in pixels
- `FB_H`, 480, framebuffer height in pixels
- `NREQ`, 2, number of client ports (2..4)

Ports:
- `CLOCK_50`  in  1  system clock; everything is in this domain
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  client i has a pixel to write
- `req_x`  in  NREQ×11  client i x coordinate
- `req_y`  in  NREQ×11  client i y coordinate
- `req_color`  in  NREQ×8  client i grey level
- `req_ready`  out  NREQ  client i's pixel is accepted this cycle (combinational)
- `clear_start`  in  1  one-cycle request to fill the whole screen
- `clear_color`  in  8  fill value, sampled with `clear_start`
- `clear_busy`  out  1  clear sweep in progress
- `clear_done`  out  1  one-cycle pulse when the sweep completes
- `fb_x`  out  11  to framebuffer `x`
- `fb_y`  out  11  to framebuffer `y`
- `fb_color`  out  8  to framebuffer `VGA_Cin`
- `fb_write`  out  1  to framebuffer `pixel_write`
- `drop_cnt`  out  16  count of off-screen pixels discarded; saturating

## Operation
- FSM has two states: IDLE and CLEAR. Reset state is IDLE.
- IDLE:
  - If `clear_start`=1: go to CLEAR, latch `clear_color`, load `cx`=`cy`=0, set `clear_busy`=1. All `req_ready` are 0 that cycle.
  - Otherwise: the round-robin arbiter grants exactly one valid client, and `req_ready[grant]`=1.
- Round-robin rule:
  - Search starts at `ptr`. After a transfer to client i, `ptr` becomes (i+1) mod NREQ.
  - `ptr` resets to 0. `ptr` is unchanged when no transfer occurs.
- Transfer happens when `req_valid[i] & req_ready[i]`.
  - If `req_x`<FB_W and `req_y`<FB_H, the pixel is written.
  - Otherwise no write; `drop_cnt` increments and saturates at 0xFFFF.
- CLEAR:
  - Emits one pixel per cycle in row-major order: `cx` runs 0..FB_W-1, then wraps to 0 and `cy` increments.
  - After pixel (FB_W-1, FB_H-1) is emitted: return to IDLE, drop `clear_busy`, pulse `clear_done`.
  - All `req_ready` stay 0 throughout.
  - `clear_start` is ignored while in CLEAR, so a sweep is never restarted.
- `req_*` inputs are ignored whenever the matching `req_ready`=0. Clients must hold valid and data until ready.

## Timing
- All outputs except `req_ready` are registered.
- Reset values: `fb_write`=0, `fb_x`=`fb_y`=0, `fb_color`=0, `clear_busy`=0, `clear_done`=0, `drop_cnt`=0, `ptr`=0.
- `reset_n` low forces these values immediately and aborts any sweep without completing it; no `clear_done` pulse.
- Client latency: a transfer in cycle n gives `fb_write`=1 with its x, y, color in cycle n+1. Throughput is 1 pixel per cycle.
- Dropped pixel: `fb_write`=0 in cycle n+1; `drop_cnt` is updated in cycle n+1.
- Clear, with `clear_start` high in cycle t:
  - `clear_busy`=1 from t+1.
  - `fb_write`=1 in cycles t+2 .. t+1+FB_W·FB_H. With defaults that is 307200 consecutive cycles.
  - Pixel (0,0) appears at t+2.
  - `clear_done`=1 and `clear_busy`=0 in cycle t+2+FB_W·FB_H−1, i.e. the cycle the last pixel is presented. A client may be granted in that same cycle.
- Simultaneous `clear_start` and client valid: clear wins, the client is not granted, and `ptr` is unchanged.
- `fb_write` never stays high in a cycle with nothing to write. There is no idle hold of a stale write.

## Structure
- Package `fb_pkg`:
  - `FB_W` and `FB_H` defaults
  - `coord_t` (logic [10:0]) and `color_t` (logic [7:0])
  - `sched_state_t` enum {IDLE, CLEAR}
- Sub-module `rr_arbiter`, parameter N:
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `grant[N]` and grant index, computed combinationally.
  - `ptr` is held in the parent.
- Parent contains: FSM, clear counters, bounds check, output registers, drop counter.

## Test plan
- Reset, then a single client0 write of (10,20,0x5A) → `req_ready[0]`=1 in that cycle; next cycle `fb_write`=1, `fb_x`=10, `fb_y`=20, `fb_color`=0x5A.
- Both clients continuously valid for 6 cycles → grants alternate 0,1,0,1,0,1. `fb_x` sequence matches the granted client each cycle.
- Client1 write at (640,5) and client0 write at (3,480) → both acknowledged, `fb_write` stays 0, `drop_cnt`=2.
- `clear_start` with `clear_color`=0x00 while client0 is valid → client0 is stalled for the whole sweep.
  - Exactly 307200 `fb_write` cycles occur, first (0,0), last (639,479).
  - `clear_done` pulses once; client0 is granted the following cycle or in the done cycle.
- `clear_start` re-asserted mid-sweep → ignored; total write count is still 307200.
- `reset_n` pulled low mid-sweep → `fb_write`=0 and `clear_busy`=0 immediately; no `clear_done` pulse; after release the block is IDLE with `ptr`=0.
